wavepipe_launch_ctrl: RTL and testbench

WAVEPIPE_LAUNCH_CTRL -- requirements
Module: wavepipe_launch_ctrl

---
 rtl/wavepipe_pkg.sv | 17 +
 rtl/wavepipe_res_fifo.sv | 46 ++++
 rtl/wavepipe_launch_ctrl.sv | 173 +++++++++++++++++
 tb/tb_wavepipe_launch_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wavepipe_pkg.sv
// Shared state encoding, width defaults and helpers for the wave-pipelined launch controller.
package wavepipe_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int DLY_W_DEF  = 4;
    localparam int ERR_W      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } wp_state_e;

    // Mismatch counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction
endpackage

// File: rtl/wavepipe_res_fifo.sv
// Synchronous result FIFO; DEPTH must be a power of two so the pointers wrap naturally.
module wavepipe_res_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + (PW+1)'(1);
                2'b01:   count_q <= count_q - (PW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
endmodule

// File: rtl/wavepipe_launch_ctrl.sv
// Launch/capture controller for wave-pipelined logic with a credit-limited result FIFO.
// Defining WAVEPIPE_CHECK_EN adds expected-value tracking, res_mismatch and err_count.
module wavepipe_launch_ctrl
    import wavepipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DLY_W      = DLY_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    input  logic [DLY_W-1:0]  cfg_delay,
    input  logic [DLY_W-1:0]  cfg_interval,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_operand,
`ifdef WAVEPIPE_CHECK_EN
    input  logic [DATA_W-1:0] cmd_expected,
    output logic              res_mismatch,
    output logic [ERR_W-1:0]  err_count,
`endif
    output logic              wp_launch,
    output logic [DATA_W-1:0] wp_operand,
    input  logic [DATA_W-1:0] wp_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data
);
    localparam int NSLOT = 1 << DLY_W;
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PW + 1;
    localparam int SUM_W = DLY_W + CNT_W + 1;
`ifdef WAVEPIPE_CHECK_EN
    localparam int ENTRY_W = 2 * DATA_W;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    wp_state_e          state_q, state_d;
    logic [DLY_W-1:0]   delay_q, interval_q, ival_q, ival_d;
    logic [NSLOT-1:0]   waves_q, waves_d, waves_kept;
    logic               launch_q;
    logic [DATA_W-1:0]  operand_q;
    logic               fire, capture, pop, fifo_push, fifo_pop, fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [SUM_W-1:0]   flight_cnt;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (stop) state_d = ST_DRAIN;
            ST_DRAIN: if ((waves_q == '0) && fifo_empty) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Credits: every wave in flight already owns a FIFO slot, so a capture never overflows.
    always_comb begin
        busy      = (state_q != ST_IDLE);
        cmd_ready = (state_q == ST_RUN) && (ival_q == '0) &&
                    ((flight_cnt + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH));
    end

    assign fire = cmd_valid && cmd_ready;

    always_comb begin
        flight_cnt = '0;
        for (int i = 0; i < NSLOT; i++) flight_cnt = flight_cnt + SUM_W'(waves_q[i]);
    end

    // Bit k of waves_q marks a wave launched k cycles ago; bit 0 coincides with wp_launch.
    always_comb begin
        waves_kept          = waves_q;
        waves_kept[delay_q] = 1'b0;
        waves_d             = (waves_kept << 1) | NSLOT'(fire);
        ival_d              = ival_q;
        if (fire)               ival_d = interval_q;
        else if (ival_q != '0)  ival_d = ival_q - DLY_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_q    <= '0;
            interval_q <= '0;
            ival_q     <= '0;
            waves_q    <= '0;
            launch_q   <= 1'b0;
            operand_q  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                delay_q    <= cfg_delay;
                interval_q <= cfg_interval;
            end
            ival_q   <= ival_d;
            waves_q  <= waves_d;
            launch_q <= fire;
            if (fire) operand_q <= cmd_operand;
        end
    end

    assign wp_launch  = launch_q;
    assign wp_operand = operand_q;

    // An empty FIFO is bypassed so a result is visible in its capture cycle.
    assign capture   = waves_q[delay_q];
    assign res_valid = !fifo_empty || capture;
    assign pop       = res_valid && res_ready;
    assign fifo_push = capture && !(fifo_empty && res_ready);
    assign fifo_pop  = pop && !fifo_empty;

    always_comb begin
        if (!fifo_empty)  res_data = fifo_head[DATA_W-1:0];
        else if (capture) res_data = wp_result;
        else              res_data = '0;
    end

`ifdef WAVEPIPE_CHECK_EN
    logic [DATA_W-1:0] exp_q [FIFO_DEPTH];
    logic [PW-1:0]     exp_wr_q, exp_rd_q;
    logic [DATA_W-1:0] cap_exp, res_exp;
    logic [ERR_W-1:0]  err_q;

    // Waves finish in launch order, so expected values queue up in the same order.
    always_ff @(posedge clk) begin
        if (fire) exp_q[exp_wr_q] <= cmd_expected;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exp_wr_q <= '0;
            exp_rd_q <= '0;
            err_q    <= '0;
        end else begin
            if (fire)    exp_wr_q <= exp_wr_q + PW'(1);
            if (capture) exp_rd_q <= exp_rd_q + PW'(1);
            if ((state_q == ST_IDLE) && start) err_q <= '0;
            else if (pop && res_mismatch)      err_q <= sat_inc(err_q);
        end
    end

    assign cap_exp      = exp_q[exp_rd_q];
    assign res_exp      = fifo_empty ? cap_exp : fifo_head[ENTRY_W-1:DATA_W];
    assign res_mismatch = res_valid && (res_data != res_exp);
    assign err_count    = err_q;
    assign fifo_wdata   = {cap_exp, wp_result};
`else
    assign fifo_wdata = wp_result;
`endif

    wavepipe_res_fifo #(
        .W     (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );
endmodule

// File: tb/tb_wavepipe_launch_ctrl.sv
// Directed bench for wavepipe_launch_ctrl; inputs change on the falling edge, outputs are read 1 ns later.
module tb_wavepipe_launch_ctrl;
    import wavepipe_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic [3:0]  cfg_delay = '0;
    logic [3:0]  cfg_interval = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_operand = '0;
    logic        wp_launch;
    logic [31:0] wp_operand;
    logic [31:0] wp_result = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
`ifdef WAVEPIPE_CHECK_EN
    logic [31:0]      cmd_expected = '0;
    logic             res_mismatch;
    logic [ERR_W-1:0] err_count;
`endif

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    wavepipe_launch_ctrl #(
        .DATA_W     (32),
        .DLY_W      (4),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .cfg_delay    (cfg_delay),
        .cfg_interval (cfg_interval),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_operand  (cmd_operand),
`ifdef WAVEPIPE_CHECK_EN
        .cmd_expected (cmd_expected),
        .res_mismatch (res_mismatch),
        .err_count    (err_count),
`endif
        .wp_launch    (wp_launch),
        .wp_operand   (wp_operand),
        .wp_result    (wp_result),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data)
    );

    task automatic doStart(input logic [3:0] dly, input logic [3:0] ivl);
        @(negedge clk);
        cfg_delay    = dly;
        cfg_interval = ivl;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic endRun();
        bit idle = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        stop      = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        for (int i = 0; i < 40 && !idle; i++) begin
            #1;
            if (busy === 1'b0) idle = 1;
            else @(negedge clk);
        end
        checks++;
        if (!idle) begin fails++; $display("[TB] FAIL endRun.idle: busy=%b after 40 cycles, want 0", busy); end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if ({busy, cmd_ready, wp_launch, res_valid} !== 4'b0000 || wp_operand !== 32'h0 || res_data !== 32'h0) begin
            fails++;
            $display("[TB] FAIL reset.outputs: busy=%b rdy=%b launch=%b rv=%b op=%h rd=%h, want all 0",
                     busy, cmd_ready, wp_launch, res_valid, wp_operand, res_data);
        end
`ifdef WAVEPIPE_CHECK_EN
        checks++;
        if (err_count !== 16'd0 || res_mismatch !== 1'b0) begin
            fails++; $display("[TB] FAIL reset.check: err=%0d mm=%b, want 0 0", err_count, res_mismatch);
        end
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_wave();
        doStart(4'd3, 4'd0);
        for (int c = 0; c <= 6; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid   = (c == 0);
            cmd_operand = (c == 0) ? 32'h1234_5678 : 32'h0;
            wp_result   = (c == 4) ? 32'hCAFE_F00D : 32'h0;
            res_ready   = (c == 5);
            #1;
            checks++;
            case (c)
                0: if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL single.ready: got %b want 1", cmd_ready); end
                1: if (wp_launch !== 1'b1 || wp_operand !== 32'h1234_5678 || res_valid !== 1'b0) begin
                       fails++; $display("[TB] FAIL single.launch: launch=%b op=%h rv=%b, want 1 12345678 0", wp_launch, wp_operand, res_valid);
                   end
                2, 3, 6: if (res_valid !== 1'b0 || wp_launch !== 1'b0) begin
                       fails++; $display("[TB] FAIL single.quiet c%0d: rv=%b launch=%b, want 0 0", c, res_valid, wp_launch);
                   end
                default: if (res_valid !== 1'b1 || res_data !== 32'hCAFE_F00D) begin
                       fails++; $display("[TB] FAIL single.result c%0d: rv=%b data=%h, want 1 cafef00d", c, res_valid, res_data);
                   end
            endcase
        end
        endRun();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ops [4] = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
        logic [31:0] rs  [4] = '{32'hA1A1_0001, 32'hB2B2_0002, 32'hC3C3_0003, 32'hD4D4_0004};
        doStart(4'd5, 4'd0);
        res_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid   = (c < 4);
            cmd_operand = (c < 4) ? ops[c] : 32'h0;
            wp_result   = (c >= 6 && c <= 9) ? rs[c-6] : 32'h0;
            #1;
            if (c < 4) begin
                checks++;
                if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL b2b.ready c%0d: got %b want 1", c, cmd_ready); end
            end
            if (c >= 1 && c <= 4) begin
                checks++;
                if (wp_launch !== 1'b1 || wp_operand !== ops[c-1]) begin
                    fails++; $display("[TB] FAIL b2b.launch c%0d: launch=%b op=%h, want 1 %h", c, wp_launch, wp_operand, ops[c-1]);
                end
            end
            if (c == 5 || c == 10) begin
                checks++;
                if (res_valid !== 1'b0) begin fails++; $display("[TB] FAIL b2b.quiet c%0d: rv=%b want 0", c, res_valid); end
            end
            if (c >= 6 && c <= 9) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== rs[c-6]) begin
                    fails++; $display("[TB] FAIL b2b.result c%0d: rv=%b data=%h, want 1 %h", c, res_valid, res_data, rs[c-6]);
                end
            end
        end
        endRun();
    endtask

    task automatic test_backpressure();
        logic        rdyExp [11] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] resExp [6]  = '{32'hB000_0003, 32'hB000_0004, 32'hB000_0005,
                                     32'hB000_0006, 32'hB000_000C, 32'hB000_000D};
        int issued = 0;
        doStart(4'd2, 4'd0);
        for (int c = 0; c <= 14; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid   = (issued < 6);
            cmd_operand = 32'h5000_0000 + 32'(issued);
            res_ready   = (c >= 8);
            wp_result   = 32'hB000_0000 + 32'(c);
            #1;
            if (c <= 10) begin
                checks++;
                if (cmd_ready !== rdyExp[c]) begin fails++; $display("[TB] FAIL bp.ready c%0d: got %b want %b", c, cmd_ready, rdyExp[c]); end
            end
            if (c >= 8 && c <= 13) begin
                checks++;
                if (res_valid !== 1'b1 || res_data !== resExp[c-8]) begin
                    fails++; $display("[TB] FAIL bp.result c%0d: rv=%b data=%h, want 1 %h", c, res_valid, res_data, resExp[c-8]);
                end
            end
            if (c == 10 || c == 11) begin
                checks++;
                if (wp_launch !== 1'b1 || wp_operand !== 32'h5000_0000 + 32'(c - 6)) begin
                    fails++; $display("[TB] FAIL bp.late_launch c%0d: launch=%b op=%h, want 1 %h", c, wp_launch, wp_operand, 32'h5000_0000 + 32'(c - 6));
                end
            end
            if (c == 14) begin
                checks++;
                if (res_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp.empty: rv=%b want 0", res_valid); end
            end
            if (cmd_valid && cmd_ready) issued++;
        end
        endRun();
    endtask

    task automatic test_stop_drain();
        doStart(4'd6, 4'd0);
        for (int c = 0; c <= 12; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid   = (c <= 1) || (c == 3);
            cmd_operand = 32'h6000_0000 + 32'(c);
            stop        = (c == 2);
            res_ready   = (c == 9 || c == 10);
            wp_result   = 32'hC000_0000 + 32'(c);
            #1;
            case (c)
                0, 1: begin
                    checks++;
                    if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL drain.ready c%0d: got %b want 1", c, cmd_ready); end
                end
                3: begin
                    checks++;
                    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
                        fails++; $display("[TB] FAIL drain.enter: busy=%b rdy=%b, want 1 0", busy, cmd_ready);
                    end
                end
                4: begin
                    checks++;
                    if (wp_launch !== 1'b0) begin fails++; $display("[TB] FAIL drain.no_launch: launch=%b want 0", wp_launch); end
                end
                9, 10: begin
                    checks++;
                    if (res_valid !== 1'b1 || res_data !== 32'hC000_0000 + 32'(c - 2) || busy !== 1'b1) begin
                        fails++; $display("[TB] FAIL drain.result c%0d: rv=%b data=%h busy=%b, want 1 %h 1", c, res_valid, res_data, busy, 32'hC000_0000 + 32'(c - 2));
                    end
                end
                11: begin
                    checks++;
                    if (res_valid !== 1'b0 || busy !== 1'b1) begin
                        fails++; $display("[TB] FAIL drain.last: rv=%b busy=%b, want 0 1", res_valid, busy);
                    end
                end
                12: begin
                    checks++;
                    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL drain.idle: busy=%b want 0", busy); end
                end
                default: ;
            endcase
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
    endtask

    task automatic test_interval_delay0();
        @(negedge clk);
        cfg_delay    = 4'd0;
        cfg_interval = 4'd2;
        start        = 1'b1;
        stop         = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        stop         = 1'b0;
        cfg_delay    = 4'd7;
        cfg_interval = 4'd0;
        for (int c = 0; c <= 4; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid   = (c <= 3);
            cmd_operand = 32'h7000_0000 + 32'(c);
            res_ready   = 1'b1;
            wp_result   = 32'h7777_0000 + 32'(c);
            #1;
            checks++;
            case (c)
                0: if (busy !== 1'b1 || cmd_ready !== 1'b1) begin
                       fails++; $display("[TB] FAIL ivl.run: busy=%b rdy=%b, want 1 1", busy, cmd_ready);
                   end
                1: if (wp_launch !== 1'b1 || res_valid !== 1'b1 || res_data !== 32'h7777_0001 || cmd_ready !== 1'b0) begin
                       fails++; $display("[TB] FAIL ivl.d0: launch=%b rv=%b data=%h rdy=%b, want 1 1 77770001 0", wp_launch, res_valid, res_data, cmd_ready);
                   end
                2: if (cmd_ready !== 1'b0 || res_valid !== 1'b0) begin
                       fails++; $display("[TB] FAIL ivl.wait: rdy=%b rv=%b, want 0 0", cmd_ready, res_valid);
                   end
                3: if (cmd_ready !== 1'b1) begin fails++; $display("[TB] FAIL ivl.expire: rdy=%b want 1", cmd_ready); end
                default: if (wp_operand !== 32'h7000_0003 || res_valid !== 1'b1 || res_data !== 32'h7777_0004) begin
                       fails++; $display("[TB] FAIL ivl.second: op=%h rv=%b data=%h, want 70000003 1 77770004", wp_operand, res_valid, res_data);
                   end
            endcase
        end
        endRun();
    endtask

    task automatic test_reset_mid();
        doStart(4'd4, 4'd0);
        for (int c = 0; c <= 9; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid   = (c == 0);
            cmd_operand = 32'h8000_0000;
            res_ready   = 1'b1;
            reset       = (c == 3);
            wp_result   = (c >= 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (c == 1) begin
                checks++;
                if (wp_launch !== 1'b1) begin fails++; $display("[TB] FAIL rstmid.launch: got %b want 1", wp_launch); end
            end
            if (c >= 3) begin
                checks++;
                if ({busy, cmd_ready, wp_launch, res_valid} !== 4'b0000 || wp_operand !== 32'h0 || res_data !== 32'h0) begin
                    fails++;
                    $display("[TB] FAIL rstmid.outputs c%0d: busy=%b rdy=%b launch=%b rv=%b op=%h rd=%h, want all 0",
                             c, busy, cmd_ready, wp_launch, res_valid, wp_operand, res_data);
                end
            end
        end
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        wp_result = 32'h0;
    endtask

`ifdef WAVEPIPE_CHECK_EN
    task automatic test_check();
        doStart(4'd1, 4'd0);
        for (int c = 0; c <= 4; c++) begin
            if (c != 0) @(negedge clk);
            cmd_valid    = (c == 0);
            cmd_operand  = 32'h9000_0000;
            cmd_expected = 32'h1;
            wp_result    = (c == 2) ? 32'h2 : 32'h0;
            res_ready    = (c == 3);
            #1;
            if (c >= 2) begin
                checks++;
                if (c <= 3 && (res_valid !== 1'b1 || res_data !== 32'h2 || res_mismatch !== 1'b1 || err_count !== 16'd0)) begin
                    fails++; $display("[TB] FAIL chk.flag c%0d: rv=%b data=%h mm=%b err=%0d, want 1 2 1 0", c, res_valid, res_data, res_mismatch, err_count);
                end
                if (c == 4 && (err_count !== 16'd1 || res_mismatch !== 1'b0)) begin
                    fails++; $display("[TB] FAIL chk.count: err=%0d mm=%b, want 1 0", err_count, res_mismatch);
                end
            end
        end
        endRun();
    endtask
`endif

    initial begin
        test_reset();
        test_single_wave();
        test_back_to_back();
        test_backpressure();
        test_stop_drain();
        test_interval_delay0();
        test_reset_mid();
`ifdef WAVEPIPE_CHECK_EN
        test_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
